// File: rtl/jk_pkg.sv
// Shared types, JK op codes and the round-robin pick used by jk_bank_arbiter.
package jk_pkg;

  // Widest requester vector the pick function supports (NREQ range is 2..8).
  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned MAX_PTRW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // First asserted request scanning ptr, ptr+1, ... wrapping modulo nreq.
  // ptr < nreq <= 8 and the offset < 8, so one conditional subtract wraps.
  function automatic logic [MAX_PTRW-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  req,
    input logic [MAX_PTRW-1:0] ptr,
    input logic [3:0]          nreq
  );
    logic [MAX_PTRW-1:0] win;
    logic                found;
    logic [3:0]          idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = 4'(ptr) + 4'(i);
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (4'(i) < nreq) && req[idx[MAX_PTRW-1:0]]) begin
        win   = idx[MAX_PTRW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop bit of the shared bank.
//   clk, rst : clock, synchronous active-high reset (q -> 0)
//   en       : update strobe; q holds when low
//   j, k     : JK inputs
//   q        : stored bit
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin owner of a shared JK register bank: grants one requester,
// latches its J/K vectors, applies one JK update, then pulses done.
//   clk, rst     : clock, synchronous active-high reset
//   req          : per-requester level request, held until done
//   cmd_j, cmd_k : packed J/K vectors, requester r owns [r*NBITS +: NBITS]
//   gnt          : registered one-hot grant (high during APPLY)
//   done         : registered one-hot completion pulse (high during ACK)
//   busy         : state != IDLE
//   q            : bank contents
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NBITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] cmd_j,
  input  logic [NREQ*NBITS-1:0] cmd_k,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [NBITS-1:0]      q
);

  localparam int unsigned PTRW = $clog2(NREQ);

  state_t            state_q, state_d;
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [PTRW-1:0]   win_q, win_d;
  logic [PTRW-1:0]   pick_c;
  logic [NBITS-1:0]  lat_j_q, lat_j_d;
  logic [NBITS-1:0]  lat_k_q, lat_k_d;
  logic [NREQ-1:0]   gnt_d, done_d;
  logic              cell_en;

  assign pick_c  = PTRW'(rr_pick(MAX_REQ'(req), MAX_PTRW'(ptr_q), 4'(NREQ)));
  assign cell_en = (state_q == APPLY);
  assign busy    = (state_q != IDLE);

  // State, grant/done, pointer and latched command registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      lat_j_q <= '0;
      lat_k_q <= '0;
      gnt     <= '0;
      done    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      lat_j_q <= lat_j_d;
      lat_k_q <= lat_k_d;
      gnt     <= gnt_d;
      done    <= done_d;
    end
  end

  // Next-state and next-output logic; gnt/done default low so each lasts one cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    lat_j_d = lat_j_q;
    lat_k_d = lat_k_q;
    gnt_d   = '0;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = APPLY;
          win_d   = pick_c;
          gnt_d   = NREQ'(1) << pick_c;
          for (int r = 0; r < NREQ; r++) begin
            if (pick_c == PTRW'(r)) begin
              lat_j_d = cmd_j[r*NBITS +: NBITS];
              lat_k_d = cmd_k[r*NBITS +: NBITS];
            end
          end
        end
      end
      APPLY: begin
        state_d = ACK;
        done_d  = NREQ'(1) << win_q;
        // Pointer advances past the winner only on service.
        if (win_q == PTRW'(NREQ - 1)) ptr_d = '0;
        else                          ptr_d = win_q + PTRW'(1);
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The bank itself: one JK cell per bit, updated in APPLY.
  for (genvar i = 0; i < NBITS; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .en  (cell_en),
      .j   (lat_j_q[i]),
      .k   (lat_k_q[i]),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
module tb_jk_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*NBITS-1:0] cmd_j;
  logic [NREQ*NBITS-1:0] cmd_k;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [NBITS-1:0]      q;

  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .cmd_j (cmd_j),
    .cmd_k (cmd_k),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .q     (q)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: transaction phase 0=waiting, 1=granted, 2=acknowledging.
  int               m_phase = 0;
  int               m_win   = 0;
  int               m_ptr   = 0;
  logic [NBITS-1:0] m_j = '0, m_k = '0, m_q = '0;
  logic [NREQ-1:0]  m_gnt = '0, m_done = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int r, input logic [NBITS-1:0] j, input logic [NBITS-1:0] k);
    cmd_j[r*NBITS +: NBITS] = j;
    cmd_k[r*NBITS +: NBITS] = k;
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare.
  task automatic tick();
    logic [NREQ-1:0]       s_req;
    logic [NREQ*NBITS-1:0] s_j, s_k;
    logic                  s_rst;
    int                    idx;
    s_req = req; s_j = cmd_j; s_k = cmd_k; s_rst = rst;
    @(posedge clk);
    #1;
    if (s_rst) begin
      m_phase = 0; m_ptr = 0; m_win = 0;
      m_j = '0; m_k = '0; m_q = '0; m_gnt = '0; m_done = '0;
    end else if (m_phase == 0) begin
      m_gnt = '0; m_done = '0;
      if (s_req != 0) begin
        for (int i = NREQ - 1; i >= 0; i--) begin
          idx = (m_ptr + i) % NREQ;
          if (s_req[idx]) m_win = idx;
        end
        m_gnt   = NREQ'(1) << m_win;
        m_j     = s_j[m_win*NBITS +: NBITS];
        m_k     = s_k[m_win*NBITS +: NBITS];
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      // JK characteristic equation: q+ = J & ~q | ~K & q
      m_q     = (m_j & ~m_q) | (~m_k & m_q);
      m_gnt   = '0;
      m_done  = NREQ'(1) << m_win;
      m_ptr   = (m_win + 1) % NREQ;
      m_phase = 2;
    end else begin
      m_done  = '0;
      m_phase = 0;
    end
    chk("gnt",  32'(gnt),  32'(m_gnt));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("q",    32'(q),    32'(m_q));
  endtask

  initial begin
    int n_srv;
    rst = 1'b1; req = '1; cmd_j = '0; cmd_k = '0;

    // Reset held two cycles with all requests up.
    tick(); tick();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();
    chk("first_gnt", 32'(gnt), 32'b0001);
    req = '0;
    tick(); tick();

    // Single requester 2 sets the high nibble.
    set_cmd(2, 8'hF0, 8'h0F);
    req = 4'b0100;
    tick(); chk("single_gnt", 32'(gnt), 32'b0100);
    tick(); chk("single_q", 32'(q), 32'hF0); chk("single_done", 32'(done), 32'b0100);
    req = '0;
    tick(); chk("single_idle", 32'(busy), 32'h0);

    // Toggle, then an all-hold command that still handshakes.
    set_cmd(1, 8'hFF, 8'hFF);
    req = 4'b0010;
    tick(); tick(); chk("toggle_q", 32'(q), 32'h0F);
    req = '0; tick();
    set_cmd(1, 8'h00, 8'h00);
    req = 4'b0010;
    tick(); tick();
    chk("hold_q", 32'(q), 32'h0F); chk("hold_done", 32'(done), 32'b0010);
    req = '0; tick();

    // Round-robin from a fresh pointer with every requester active.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int r = 0; r < NREQ; r++) set_cmd(r, 8'($urandom), 8'($urandom));
    req = '1;
    n_srv = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (gnt != 0) begin
        chk("rr_order", 32'(gnt), 32'(1 << (n_srv % NREQ)));
        n_srv++;
      end
    end
    chk("rr_count", 32'(n_srv), 32'd8);
    req = '0; tick();

    // Withdraw request and change command during APPLY.
    rst = 1'b1; tick(); rst = 1'b0;
    set_cmd(3, 8'h01, 8'h00);
    req = 4'b1000;
    tick();
    req = '0; set_cmd(3, 8'hFF, 8'h00);
    tick(); chk("wd_q", 32'(q), 32'h01); chk("wd_done", 32'(done), 32'b1000);
    tick();

    // Reset during APPLY discards the command and the pointer.
    set_cmd(0, 8'hFF, 8'h00);
    req = 4'b0001;
    tick();
    rst = 1'b1;
    tick(); chk("mid_q", 32'(q), 32'h00); chk("mid_done", 32'(done), 32'h0);
    rst = 1'b0; req = '0;
    tick(); chk("mid_nodone", 32'(done), 32'h0);
    req = '1;
    tick(); chk("mid_ptr", 32'(gnt), 32'b0001);
    req = '0; tick(); tick();

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      req   = NREQ'($urandom);
      cmd_j = {$urandom, $urandom};
      cmd_k = {$urandom, $urandom};
      rst   = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
